lsu_align_unit: RTL and testbench
=================================

Name: lsu_align_unit

Overview:
Parametrised load/store alignment unit for the pipelined CPU's MEM stage. It is the sequential successor to the combinational load-extension logic. It accepts one load/store request at a time and drives a word-wide data-memory port with byte enables. Misaligned accesses that cross a bus word are split into two bus transactions. Load data is merged, sign- or zero-extended to XLEN and returned with a single-cycle response pulse.

Parameters:
XLEN, 32, data/bus width; legal values 32 or 64. Enables LD/LWU/SD when 64.
ADDR_W, 32, address width.
MISALIGN_SPLIT, 1, 1 = split word-crossing accesses into two transactions; 0 = return a misalign error with no bus traffic.

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  pipeline request valid
req_ready  output  1  unit can accept a request
req_store  input  1  1 = store, 0 = load
req_func3  input  3  RISC-V funct3 width/sign code
req_addr  input  ADDR_W  byte address
req_wdata  input  XLEN  store data, LSB-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  XLEN  extended load data; 0 for stores
resp_err  output  1  misaligned (MISALIGN_SPLIT=0) or illegal funct3
mem_req  output  1  bus request, held until ack
mem_we  output  1  bus write
mem_addr  output  ADDR_W  bus address, aligned to XLEN/8
mem_be  output  XLEN/8  byte enables
mem_wdata  output  XLEN  lane-shifted store data
mem_ack  input  1  bus completion, sampled on clk
mem_rdata  input  XLEN  bus read data, valid with mem_ack

Behaviour:
- Reset: all listed outputs are 0 and state = IDLE. req_ready is forced 0 while rst=1.
- States:
  - IDLE: req_ready=1. On req_valid: decode; go ACC0, or go RESP if error.
  - ACC0: mem_req=1. On mem_ack: go ACC1 if split, else RESP.
  - ACC1: second beat at mem_addr+XLEN/8. On mem_ack: go RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; with XLEN=64 also 011 LD and 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW; with XLEN=64 also 011 SD.
  - Any other code gives resp_err=1 with no bus traffic.
- Size and offset: size = 1/2/4/8 bytes; off = addr mod (XLEN/8).
- Split rule: split iff off+size > XLEN/8. A misaligned access that stays within one word (e.g. LH at 0x1 with XLEN=32) is a single beat and is not an error.
- With MISALIGN_SPLIT=0, any addr mod size != 0 gives resp_err=1.
- Byte enables:
  - Beat 0: be = ((1<<size)-1) << off, truncated to XLEN/8 lanes.
  - Beat 1: the remaining low lanes.
  - mem_wdata = wdata << (8*off) on beat 0; wdata >> (8*(XLEN/8-off)) on beat 1.
- Load merge: beat-0 rdata is captured into a holding register on ack. The result is assembled from beat-0 upper lanes and beat-1 lower lanes, then extended. Signed loads replicate bit 8*size-1; unsigned loads zero-fill.
- mem_addr, mem_we, mem_be and mem_wdata are registered and stable while mem_req=1. mem_req drops the cycle after ack.
- Latency from accept edge T:
  - Aligned access with zero-wait ack: resp_valid at T+2.
  - Split access: T+3.
  - Error: T+1.
- Reset mid-transaction: abandon the transaction, mem_req=0 the next cycle, no resp_valid. The bus tolerates the dropped request.
- Requests arriving while not IDLE are not accepted (req_ready=0). The pipeline holds them.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams
  - state encoding (IDLE/ACC0/ACC1/RESP)
  - size_of(funct3) function
  - is_signed(funct3) function
- Sub-module load_extend (combinational): takes the merged word, off, size and signed flag, and produces the XLEN result. It is reused by the writeback bypass path.

Test Plan:
1. XLEN=32, LB addr 0x1003, ack next cycle with rdata 0x80FF1234 -> mem_be=1000, resp_rdata=0xFFFFFF80, resp_valid at T+2.
2. LHU addr 0x1002, rdata 0xBEEF0000 -> single beat, be=1100, resp_rdata=0x0000BEEF.
3. LW addr 0x1001:
   - beat 0 at 0x1000, be=1110, rdata 0x44332211
   - beat 1 at 0x1004, be=0001, rdata 0x88776655
   - -> resp_rdata=0x55443322 at T+3.
4. SH addr 0x1003, wdata 0x0000ABCD:
   - beat 0 at 0x1000, be=1000, wdata[31:24]=0xCD
   - beat 1 at 0x1004, be=0001, wdata[7:0]=0xAB
   - -> resp_rdata=0.
5. MISALIGN_SPLIT=0, LW at 0x1002 -> mem_req never asserts, resp_valid=1 and resp_err=1 at T+1. funct3=011 with XLEN=32 gives the same result.
6. rst asserted in ACC1 with mem_ack withheld -> mem_req=0 next cycle, no resp_valid, req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : funct3 codes, FSM state encoding and size/sign helpers  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Access size in bytes is encoded by the low two funct3 bits.
  function automatic logic [3:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    size_of = 4'd1;
      2'd1:    size_of = 4'd2;
      2'd2:    size_of = 4'd4;
      default: size_of = 4'd8;
    endcase
  endfunction

  function automatic logic is_signed(input logic [2:0] f3);
    is_signed = ~f3[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align_unit_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend : right-justifies a two-beat lane pair and sign/zero extends   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module load_extend #(
  parameter  int XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2*XLEN-1:0] word,
  input  logic [OFF_W-1:0]  off,
  input  logic [3:0]        size,
  input  logic              sign_ext,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] shifted;
  logic              sbit;

  always_comb begin
    shifted = word >> {off, 3'b000};
    sbit    = 1'b0;
    for (int i = 0; i < 2 * XLEN; i++) begin
      if (i == 8 * int'(size) - 1) sbit = shifted[i];
    end
    sbit = sbit & sign_ext;
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (i < 8 * int'(size)) ? shifted[i] : sbit;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsu_align_unit.sv
// ---------------------------------------------------------------------------
// lsu_align_unit : load/store aligner with two-beat split of word-crossing accesses (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_func3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  state_t              state;
  logic                store_q, sign_q, split_q;
  logic [OFF_W-1:0]    off_q;
  logic [3:0]          size_q;
  logic [ADDR_W-1:0]   addr1_q;
  logic [NB-1:0]       be1_q;
  logic [XLEN-1:0]     wdata1_q, hold_q;

  logic [3:0]          d_size;
  logic [OFF_W-1:0]    d_off;
  logic                d_legal, d_mis, d_cross, d_err;
  logic [2*NB-1:0]     d_span;
  logic [2*XLEN-1:0]   d_wide;
  logic [ADDR_W-1:0]   d_addr0;
  logic [2*XLEN-1:0]   ext_word;
  logic [XLEN-1:0]     ext_data;

  always_comb begin
    d_size = size_of(req_func3);
    d_off  = req_addr[OFF_W-1:0];
    if (req_store) begin
      d_legal = (req_func3 == F3_B) || (req_func3 == F3_H) || (req_func3 == F3_W) ||
                ((XLEN == 64) && (req_func3 == F3_D));
    end else begin
      d_legal = (req_func3 == F3_B)  || (req_func3 == F3_H)  || (req_func3 == F3_W) ||
                (req_func3 == F3_BU) || (req_func3 == F3_HU) ||
                ((XLEN == 64) && ((req_func3 == F3_D) || (req_func3 == F3_WU)));
    end
    d_mis   = (req_addr[3:0] & (d_size - 4'd1)) != 4'd0;
    d_cross = (int'(d_off) + int'(d_size)) > NB;
    d_err   = !d_legal || ((MISALIGN_SPLIT == 0) && d_mis);
    // Lane span over two adjacent bus words; upper half is the second beat.
    for (int i = 0; i < 2 * NB; i++) begin
      d_span[i] = (i >= int'(d_off)) && (i < int'(d_off) + int'(d_size));
    end
    d_wide  = {{XLEN{1'b0}}, req_wdata} << {d_off, 3'b000};
    d_addr0 = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  assign ext_word = (state == ST_ACC1) ? {mem_rdata, hold_q} : {{XLEN{1'b0}}, mem_rdata};

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word     (ext_word),
    .off      (off_q),
    .size     (size_q),
    .sign_ext (sign_q),
    .result   (ext_data)
  );

  assign req_ready = (state == ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      store_q    <= 1'b0;
      sign_q     <= 1'b0;
      split_q    <= 1'b0;
      off_q      <= '0;
      size_q     <= '0;
      addr1_q    <= '0;
      be1_q      <= '0;
      wdata1_q   <= '0;
      hold_q     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            store_q <= req_store;
            sign_q  <= is_signed(req_func3);
            off_q   <= d_off;
            size_q  <= d_size;
            if (d_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= ST_RESP;
            end else begin
              split_q   <= d_cross;
              addr1_q   <= d_addr0 + ADDR_W'(NB);
              be1_q     <= d_span[2*NB-1:NB];
              wdata1_q  <= d_wide[2*XLEN-1:XLEN];
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= d_addr0;
              mem_be    <= d_span[NB-1:0];
              mem_wdata <= d_wide[XLEN-1:0];
              state     <= ST_ACC0;
            end
          end
        end
        ST_ACC0: begin
          if (mem_ack) begin
            hold_q <= mem_rdata;
            if (split_q) begin
              mem_addr  <= addr1_q;
              mem_be    <= be1_q;
              mem_wdata <= wdata1_q;
              state     <= ST_ACC1;
            end else begin
              mem_req    <= 1'b0;
              resp_valid <= 1'b1;
              resp_rdata <= store_q ? '0 : ext_data;
              state      <= ST_RESP;
            end
          end
        end
        ST_ACC1: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= store_q ? '0 : ext_data;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_align_unit.sv
// ---------------------------------------------------------------------------
// tb_lsu_align_unit : directed checks of the load/store alignment unit (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_ns, req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_ack, ack_ns;
  logic [31:0] mem_rdata;

  logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        req_ready_ns, resp_valid_ns, resp_err_ns, mem_req_ns, mem_we_ns;
  logic [31:0] resp_rdata_ns, mem_addr_ns, mem_wdata_ns;
  logic [3:0]  mem_be_ns;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lsu_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_func3(req_func3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_ready(req_ready_ns),
    .req_store(req_store), .req_func3(req_func3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid_ns), .resp_rdata(resp_rdata_ns),
    .resp_err(resp_err_ns), .mem_req(mem_req_ns), .mem_we(mem_we_ns),
    .mem_addr(mem_addr_ns), .mem_be(mem_be_ns), .mem_wdata(mem_wdata_ns),
    .mem_ack(ack_ns), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request at the current negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_store = st;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid_ns = 1'b0; req_store = 1'b0;
    req_func3 = 3'b000; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; ack_ns = 1'b0; mem_rdata = '0;

    tick();
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", req_ready, 1);

    // LB 0x1003, single beat, sign extension of 0x80
    issue(1'b0, 3'b000, 32'h1003, 32'h0);
    chk("lb_mem_req", mem_req, 1);
    chk("lb_mem_addr", mem_addr, 32'h1000);
    chk("lb_mem_be", mem_be, 4'b1000);
    chk("lb_mem_we", mem_we, 0);
    chk("lb_req_ready_busy", req_ready, 0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF1234;
    tick();
    mem_ack = 1'b0;
    chk("lb_resp_valid_t2", resp_valid, 1);
    chk("lb_resp_rdata", resp_rdata, 32'hFFFFFF80);
    chk("lb_resp_err", resp_err, 0);
    chk("lb_mem_req_drop", mem_req, 0);
    tick();
    chk("lb_resp_pulse_end", resp_valid, 0);
    chk("lb_ready_again", req_ready, 1);

    // LHU 0x1002, zero extension
    issue(1'b0, 3'b101, 32'h1002, 32'h0);
    chk("lhu_mem_be", mem_be, 4'b1100);
    mem_ack = 1'b1; mem_rdata = 32'hBEEF0000;
    tick();
    mem_ack = 1'b0;
    chk("lhu_resp_valid", resp_valid, 1);
    chk("lhu_resp_rdata", resp_rdata, 32'h0000BEEF);
    tick();

    // LH 0x1001: misaligned but inside one word -> single beat, signed
    issue(1'b0, 3'b001, 32'h1001, 32'h0);
    chk("lh_in_word_be", mem_be, 4'b0110);
    mem_ack = 1'b1; mem_rdata = 32'h0080FF00;
    tick();
    mem_ack = 1'b0;
    chk("lh_in_word_valid", resp_valid, 1);
    chk("lh_in_word_rdata", resp_rdata, 32'hFFFF80FF);
    chk("lh_in_word_err", resp_err, 0);
    tick();

    // LW 0x1001: split into two beats
    issue(1'b0, 3'b010, 32'h1001, 32'h0);
    chk("lw_b0_addr", mem_addr, 32'h1000);
    chk("lw_b0_be", mem_be, 4'b1110);
    mem_ack = 1'b1; mem_rdata = 32'h44332211;
    tick();
    chk("lw_b1_req", mem_req, 1);
    chk("lw_b1_addr", mem_addr, 32'h1004);
    chk("lw_b1_be", mem_be, 4'b0001);
    chk("lw_no_early_resp", resp_valid, 0);
    mem_rdata = 32'h88776655;
    tick();
    mem_ack = 1'b0;
    chk("lw_resp_valid_t3", resp_valid, 1);
    chk("lw_resp_rdata", resp_rdata, 32'h55443322);
    chk("lw_mem_req_drop", mem_req, 0);
    tick();

    // SH 0x1003 wdata 0xABCD: split store
    issue(1'b1, 3'b001, 32'h1003, 32'h0000ABCD);
    chk("sh_b0_we", mem_we, 1);
    chk("sh_b0_addr", mem_addr, 32'h1000);
    chk("sh_b0_be", mem_be, 4'b1000);
    chk("sh_b0_wdata", mem_wdata, 32'hCD000000);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("sh_b1_addr", mem_addr, 32'h1004);
    chk("sh_b1_be", mem_be, 4'b0001);
    chk("sh_b1_wdata", mem_wdata, 32'h000000AB);
    tick();
    mem_ack = 1'b0;
    chk("sh_resp_valid", resp_valid, 1);
    chk("sh_resp_rdata", resp_rdata, 32'h0);
    tick();

    // MISALIGN_SPLIT=0: LW 0x1002 is an error at T+1 without bus traffic
    req_valid_ns = 1'b1; req_store = 1'b0; req_func3 = 3'b010; req_addr = 32'h1002;
    tick();
    req_valid_ns = 1'b0;
    chk("ns_lw_resp_valid", resp_valid_ns, 1);
    chk("ns_lw_resp_err", resp_err_ns, 1);
    chk("ns_lw_mem_req", mem_req_ns, 0);
    tick();
    chk("ns_lw_pulse_end", resp_valid_ns, 0);

    // MISALIGN_SPLIT=0: LH 0x1001 stays in-word but is still misaligned
    req_valid_ns = 1'b1; req_func3 = 3'b001; req_addr = 32'h1001;
    tick();
    req_valid_ns = 1'b0;
    chk("ns_lh_resp_err", resp_err_ns, 1);
    chk("ns_lh_mem_req", mem_req_ns, 0);
    tick();

    // funct3=011 is illegal with XLEN=32
    issue(1'b0, 3'b011, 32'h1000, 32'h0);
    chk("ld32_resp_valid", resp_valid, 1);
    chk("ld32_resp_err", resp_err, 1);
    chk("ld32_mem_req", mem_req, 0);
    tick();
    chk("ld32_err_clear", resp_err, 0);

    // Reset while waiting in the second beat
    issue(1'b0, 3'b010, 32'h1001, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h44332211;
    tick();
    mem_ack = 1'b0;
    chk("rst_mid_in_acc1", mem_req, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_resp_valid", resp_valid, 0);
    chk("rst_mid_ready_low", req_ready, 0);
    rst = 1'b0;
    tick();
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_no_resp", resp_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
